// File: rtl/heat_timer_bank.sv
// Three independent heat countdown channels (PLA, ABS, TPU) with shared abort.
// Optional shared tick prescaler enabled by HEAT_TIMER_PRESCALE_EN.
module heat_timer_bank #(
    parameter int CNT_W     = 8,
    parameter int PLA_CYC   = 8,
    parameter int ABS_CYC   = 10,
    parameter int TPU_CYC   = 8,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EN,
    input  logic             EN0,
    input  logic             EN1,
    input  logic             AB,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             busy,
    output logic [CNT_W-1:0] rem1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           st_q  [3];
    state_t           st_d  [3];
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [CNT_W-1:0] load  [3];
    logic [2:0]       en;
    logic             tick;

    assign en      = {EN1, EN0, EN};
    assign load[0] = CNT_W'(PLA_CYC - 1);
    assign load[1] = CNT_W'(ABS_CYC - 1);
    assign load[2] = CNT_W'(TPU_CYC - 1);

`ifdef HEAT_TIMER_PRESCALE_EN
    localparam int PW = $clog2(PRESC_DIV);

    logic [PW-1:0] pc_q;

    assign tick = (pc_q == PW'(PRESC_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset || AB) begin
            pc_q <= '0;
        end else if (tick) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_q + PW'(1);
        end
    end
`else
    // Every clock is a tick; the divider setting has no effect here.
    assign tick = (PRESC_DIV >= 0);
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (AB) begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        if (en[i]) begin
                            st_d[i]  = COUNT;
                            cnt_d[i] = load[i];
                        end
                    end
                    COUNT: begin
                        if (!en[i]) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                        end else if (tick) begin
                            if (cnt_q[i] == '0) begin
                                st_d[i] = DONE;
                            end else begin
                                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (!en[i]) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                        end
                    end
                    default: begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Outputs are decoded from next state so they land in flops this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
            T1   <= 1'b0;
            T2   <= 1'b0;
            T3   <= 1'b0;
            busy <= 1'b0;
            rem1 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            T1   <= (st_d[0] == DONE);
            T2   <= (st_d[1] == DONE);
            T3   <= (st_d[2] == DONE);
            busy <= (st_d[0] == COUNT) ||
                    (st_d[1] == COUNT) ||
                    (st_d[2] == COUNT);
            rem1 <= (st_d[0] == COUNT) ? cnt_d[0] : '0;
        end
    end

endmodule

// File: tb/tb_heat_timer_bank.sv
// Randomised and directed bench for heat_timer_bank (default build).
// Reference model tracks how many edges each enable has been held.
module tb_heat_timer_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       EN = 1'b0;
    logic       EN0 = 1'b0;
    logic       EN1 = 1'b0;
    logic       AB = 1'b0;
    logic       T1;
    logic       T2;
    logic       T3;
    logic       busy;
    logic [7:0] rem1;

    int n_run  = 0;
    int n_fail = 0;
    int held [3];
    int cyc  [3];

    always #5 clk = ~clk;

    heat_timer_bank dut (
        .clk   (clk),
        .reset (reset),
        .EN    (EN),
        .EN0   (EN0),
        .EN1   (EN1),
        .AB    (AB),
        .T1    (T1),
        .T2    (T2),
        .T3    (T3),
        .busy  (busy),
        .rem1  (rem1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic ab, input logic e,
                        input logic e0, input logic e1);
        logic [2:0] ev;
        logic       bz;
        int         rm;
        @(negedge clk);
        reset = r;
        AB    = ab;
        EN    = e;
        EN0   = e0;
        EN1   = e1;
        ev    = {e1, e0, e};
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!r || ab || !ev[i]) held[i] = 0;
            else if (held[i] <= cyc[i]) held[i] = held[i] + 1;
        end
        bz = 1'b0;
        for (int i = 0; i < 3; i++)
            if (held[i] >= 1 && held[i] <= cyc[i]) bz = 1'b1;
        rm = (held[0] >= 1 && held[0] <= cyc[0]) ? cyc[0] - held[0] : 0;
        #1;
        chk("T1",   {31'd0, T1},   {31'd0, held[0] == cyc[0] + 1});
        chk("T2",   {31'd0, T2},   {31'd0, held[1] == cyc[1] + 1});
        chk("T3",   {31'd0, T3},   {31'd0, held[2] == cyc[2] + 1});
        chk("busy", {31'd0, busy}, {31'd0, bz});
        chk("rem1", {24'd0, rem1}, rm);
    endtask

    initial begin
        logic r, ab, e, e0, e1;
        cyc[0] = 8;
        cyc[1] = 10;
        cyc[2] = 8;
        for (int i = 0; i < 3; i++) held[i] = 0;

        repeat (3) step(0, 0, 1, 1, 1);
        repeat (2) step(1, 0, 0, 0, 0);

        repeat (12) step(1, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);

        repeat (2) step(1, 0, 1, 0, 1);
        repeat (14) step(1, 0, 1, 1, 1);
        repeat (2) step(1, 0, 0, 0, 0);

        repeat (5) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (13) step(1, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0);

        repeat (4) step(1, 0, 1, 1, 0);
        repeat (3) step(1, 1, 1, 1, 0);
        repeat (12) step(1, 0, 1, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0);

        r = 1'b1; ab = 1'b0; e = 1'b0; e0 = 1'b0; e1 = 1'b0;
        for (int c = 0; c < 500; c++) begin
            r  = ($urandom_range(0, 99) != 0);
            ab = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) e  = ~e;
            if ($urandom_range(0, 13) == 0) e0 = ~e0;
            if ($urandom_range(0, 9) == 0)  e1 = ~e1;
            step(r, ab, e, e0, e1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
